// File: rtl/fir_pkg.sv
// Shared types, default sizes and arithmetic helpers for the multichannel TDM FIR.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} state_t;

    localparam int DEF_N_CH    = 3;
    localparam int DEF_N_TAPS  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_COEFF_W = 16;
    localparam int DEF_N_BANKS = 4;
    localparam int DEF_ACC_W   = DEF_DATA_W + DEF_COEFF_W + $clog2(DEF_N_TAPS);

    function automatic int acc_width(int data_w, int coeff_w, int n_taps);
        return data_w + coeff_w + $clog2(n_taps);
    endfunction

    function automatic longint sat_hi(int data_w);
        return (longint'(1) << (data_w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(int data_w);
        return -(longint'(1) << (data_w - 1));
    endfunction

    // Bank 0 passes tap 0 at just under unity gain; everything else is silent.
    function automatic longint default_coef(int bank, int tap, int coeff_w);
        return (bank == 0 && tap == 0) ? (longint'(1) << (coeff_w - 1)) - 1 : 0;
    endfunction

endpackage

// File: rtl/fir_multichannel_tdm_if.sv
// Sample, coefficient-write and result signals of the TDM FIR, bundled with direction modports.
interface fir_multichannel_tdm_if
    import fir_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int N_TAPS  = DEF_N_TAPS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int N_BANKS = DEF_N_BANKS
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BSEL_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int TAP_W  = $clog2(N_TAPS);

    logic                             in_valid;
    logic                             in_ready;
    logic [N_CH-1:0][DATA_W-1:0]      in_data;
    logic [N_CH-1:0][BSEL_W-1:0]      bank_sel;
    logic                             hist_clear;
    logic                             coef_wr_en;
    logic                             coef_wr_ready;
    logic [CH_W-1:0]                  coef_ch;
    logic [BSEL_W-1:0]                coef_bank;
    logic [TAP_W-1:0]                 coef_idx;
    logic [COEFF_W-1:0]               coef_data;
    logic                             out_valid;
    logic [N_CH-1:0][DATA_W-1:0]      out_data;
    logic [N_CH-1:0]                  out_sat;
    logic                             busy;

    modport master (
        output in_valid, in_data, bank_sel, hist_clear,
               coef_wr_en, coef_ch, coef_bank, coef_idx, coef_data,
        input  in_ready, coef_wr_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  in_valid, in_data, bank_sel, hist_clear,
               coef_wr_en, coef_ch, coef_bank, coef_idx, coef_data,
        output in_ready, coef_wr_ready, out_valid, out_data, out_sat, busy
    );

endinterface

// File: rtl/fir_mac_sat.sv
// Signed multiply-accumulate with clear-on-first-tap, plus floor shift and clamp to DATA_W.
module fir_mac_sat
    import fir_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      first,
    input  logic signed [DATA_W-1:0]  sample,
    input  logic signed [COEFF_W-1:0] coef,
    output logic signed [DATA_W-1:0]  result,
    output logic                      sat
);
    localparam int PROD_W = DATA_W + COEFF_W;
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(DATA_W));
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(DATA_W));

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_d, base, shifted;

    always_comb begin
        prod    = sample * coef;
        base    = first ? '0 : acc_q;
        acc_d   = acc_q;
        if (en) begin
            acc_d = base + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
        // Arithmetic shift rounds toward minus infinity, matching the Q1 coefficient scale.
        shifted = acc_q >>> (COEFF_W - 1);
        result  = shifted[DATA_W-1:0];
        sat     = 1'b0;
        if (shifted > HI) begin
            result = HI[DATA_W-1:0];
            sat    = 1'b1;
        end else if (shifted < LO) begin
            result = LO[DATA_W-1:0];
            sat    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fir_multichannel_tdm.sv
// N_CH-channel FIR sharing one MAC: per-channel history and coefficient banks, one channel at a time.
module fir_multichannel_tdm
    import fir_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int N_TAPS  = DEF_N_TAPS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int N_BANKS = DEF_N_BANKS
) (
    input logic                    sys_clk,
    input logic                    reset_n,
    fir_multichannel_tdm_if.slave  bus
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BSEL_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int TAP_W  = $clog2(N_TAPS);
    localparam int ACC_W  = acc_width(DATA_W, COEFF_W, N_TAPS);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

    state_t                      state_q, state_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [TAP_W-1:0]            tap_q, tap_d;
    logic [N_CH-1:0][BSEL_W-1:0] bsel_q, bsel_d;
    logic [N_CH-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic [N_CH-1:0]             out_sat_q, out_sat_d;
    logic                        out_valid_q, out_valid_d;

    logic signed [DATA_W-1:0]  hist_q [N_CH][N_TAPS];
    logic signed [DATA_W-1:0]  hist_d [N_CH][N_TAPS];
    logic signed [COEFF_W-1:0] coef_q [N_CH][N_BANKS][N_TAPS];
    logic signed [COEFF_W-1:0] coef_d [N_CH][N_BANKS][N_TAPS];

    logic                      idle, accept, coef_we;
    logic signed [DATA_W-1:0]  mac_sample, mac_result;
    logic signed [COEFF_W-1:0] mac_coef;
    logic                      mac_sat;

    assign idle    = (state_q == IDLE);
    assign accept  = idle && bus.in_valid;
    assign coef_we = idle && bus.coef_wr_en && (int'(bus.coef_ch) < N_CH);

    assign bus.in_ready      = idle;
    assign bus.coef_wr_ready = idle;
    assign bus.busy          = !idle;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_sat       = out_sat_q;

    assign mac_sample = hist_q[ch_q][tap_q];
    assign mac_coef   = coef_q[ch_q][bsel_q[ch_q]][tap_q];

    fir_mac_sat #(
        .DATA_W  (DATA_W),
        .COEFF_W (COEFF_W),
        .ACC_W   (ACC_W)
    ) u_mac (
        .clk    (sys_clk),
        .rst_n  (reset_n),
        .en     (state_q == MAC),
        .first  (tap_q == '0),
        .sample (mac_sample),
        .coef   (mac_coef),
        .result (mac_result),
        .sat    (mac_sat)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        tap_d       = tap_q;
        bsel_d      = bsel_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    ch_d    = '0;
                    tap_d   = '0;
                    bsel_d  = bus.bank_sel;
                end
            end
            MAC: begin
                tap_d = tap_q + 1'b1;
                if (tap_q == LAST_TAP) begin
                    tap_d   = '0;
                    state_d = SAT;
                end
            end
            SAT: begin
                out_data_d[ch_q] = mac_result;
                out_sat_d[ch_q]  = mac_sat;
                if (ch_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = MAC;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear precedes the shift so a simultaneous sample survives at tap 0.
    always_comb begin
        hist_d = hist_q;
        if (idle && bus.hist_clear) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < N_TAPS; t++) begin
                    hist_d[c][t] = '0;
                end
            end
        end
        if (accept) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = N_TAPS - 1; t > 0; t--) begin
                    hist_d[c][t] = hist_d[c][t-1];
                end
                hist_d[c][0] = bus.in_data[c];
            end
        end
    end

    always_comb begin
        coef_d = coef_q;
        if (coef_we) begin
            coef_d[bus.coef_ch][bus.coef_bank][bus.coef_idx] = bus.coef_data;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            tap_q       <= '0;
            bsel_q      <= '0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            tap_q       <= tap_d;
            bsel_q      <= bsel_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < N_TAPS; t++) begin
                    hist_q[c][t] <= '0;
                end
                for (int b = 0; b < N_BANKS; b++) begin
                    for (int t = 0; t < N_TAPS; t++) begin
                        coef_q[c][b][t] <= COEFF_W'(default_coef(b, t, COEFF_W));
                    end
                end
            end
        end else begin
            hist_q <= hist_d;
            coef_q <= coef_d;
        end
    end

endmodule
